// File: rtl/onehot_wsel_pkg.sv
// Shared types for the one-hot write-select block.
// Mode and FSM state encodings.
package onehot_wsel_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_CONT   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   function automatic logic is_sweep_mode(mode_t m);
      return (m == MODE_SINGLE) || (m == MODE_CONT);
   endfunction

endpackage

// File: rtl/onehot_wsel_dec.sv
// Binary to one-hot decoder.
// Purely combinational, one bit set per address.
module onehot_dec #(
   parameter int ADDR_W = 5,
   localparam int OUT_W = 2**ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [OUT_W-1:0]  oh
);

   // single set bit at the addressed position
   always_comb begin
      oh = '0;
      oh[addr] = 1'b1;
   end

endmodule

// File: rtl/onehot_wsel.sv
// One-hot write select: direct address or sweep.
// All outputs registered, one cycle of latency.
module onehot_wsel
   import onehot_wsel_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   localparam int OUT_W = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              start,
   input  logic              stall,
   input  logic              stop,
   output logic [OUT_W-1:0]  out,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
   localparam logic              ONE_ENT = (DEPTH == 1);

   state_t            state, state_d;
   logic [ADDR_W-1:0] cnt, cnt_d;
   logic              cont, cont_d;
   mode_t             mode_s;
   logic              launch, hit, last, in_rng;
   logic [ADDR_W-1:0] sel;
   logic [OUT_W-1:0]  dec;
   logic              fire_d, done_d, err_d;

   assign mode_s = mode_t'(mode);
   assign launch = (state == ST_IDLE) && is_sweep_mode(mode_s) && start;
   assign in_rng = {1'b0, in_addr} < DEPTH_X;
   assign hit    = (state == ST_SWEEP) && !stop && !stall;
   assign last   = (cnt == LAST);
   assign sel    = (state == ST_SWEEP) ? cnt :
                   (launch ? '0 : in_addr);
   assign busy   = (state == ST_SWEEP);

   onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
      .addr (sel),
      .oh   (dec)
   );

   // FSM state, sweep counter and latched sweep mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         cont  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         cont  <= cont_d;
      end
   end

   // next state: launch, advance, wrap, stall hold, stop abort
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cont_d  = cont;
      unique case (state)
         ST_IDLE: begin
            if (launch) begin
               cont_d = (mode_s == MODE_CONT);
               if (ONE_ENT) begin
                  cnt_d   = '0;
                  state_d = (mode_s == MODE_CONT) ?
                            ST_SWEEP : ST_IDLE;
               end else begin
                  cnt_d   = ADDR_W'(1);
                  state_d = ST_SWEEP;
               end
            end
         end
         ST_SWEEP: begin
            if (stop) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (!stall) begin
               if (last) begin
                  cnt_d = '0;
                  if (!cont) state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt + ADDR_W'(1);
               end
            end
         end
      endcase
   end

   // output decisions for the next registered cycle
   always_comb begin
      fire_d = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (launch) begin
               fire_d = 1'b1;
               done_d = ONE_ENT;
            end else if (!is_sweep_mode(mode_s) && in_valid) begin
               fire_d = in_rng;
               err_d  = !in_rng;
            end
         end
         ST_SWEEP: begin
            if (hit) begin
               fire_d = 1'b1;
               done_d = last;
            end
         end
      endcase
   end

   // registered outputs; out is zero unless a select fires
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         out       <= fire_d ? dec : '0;
         out_valid <= fire_d;
         done      <= done_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_onehot_wsel.sv
// Directed bench for onehot_wsel.
// Five instances cover DEPTH 32, 20, 8, 4 and 1.
module tb_onehot_wsel;

   localparam int AW = 5;
   localparam int OW = 2**AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          in_valid = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          stop = 1'b0;

   logic [OW-1:0] o32, o20, o8, o4, o1;
   logic v32, v20, v8, v4, v1;
   logic b32, b20, b8, b4, b1;
   logic d32, d20, d8, d4, d1;
   logic e32, e20, e8, e4, e1;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   onehot_wsel #(.ADDR_W(AW), .DEPTH(32)) u32 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
      .in_addr(in_addr), .start(start), .stall(stall), .stop(stop),
      .out(o32), .out_valid(v32), .busy(b32), .done(d32), .err(e32));
   onehot_wsel #(.ADDR_W(AW), .DEPTH(20)) u20 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
      .in_addr(in_addr), .start(start), .stall(stall), .stop(stop),
      .out(o20), .out_valid(v20), .busy(b20), .done(d20), .err(e20));
   onehot_wsel #(.ADDR_W(AW), .DEPTH(8)) u8 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
      .in_addr(in_addr), .start(start), .stall(stall), .stop(stop),
      .out(o8), .out_valid(v8), .busy(b8), .done(d8), .err(e8));
   onehot_wsel #(.ADDR_W(AW), .DEPTH(4)) u4 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
      .in_addr(in_addr), .start(start), .stall(stall), .stop(stop),
      .out(o4), .out_valid(v4), .busy(b4), .done(d4), .err(e4));
   onehot_wsel #(.ADDR_W(AW), .DEPTH(1)) u1 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
      .in_addr(in_addr), .start(start), .stall(stall), .stop(stop),
      .out(o1), .out_valid(v1), .busy(b1), .done(d1), .err(e1));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mode = 2'b00; in_valid = 1'b0; in_addr = '0;
      start = 1'b0; stall = 1'b0; stop = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      // async reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_out", o32, 0);
      chk("rst_ov", {31'd0, v32}, 0);
      chk("rst_busy", {31'd0, b32}, 0);
      chk("rst_done", {31'd0, d32}, 0);
      chk("rst_err", {31'd0, e32}, 0);
      step();
      rst = 1'b0;

      // direct mode, every address on DEPTH=32
      mode = 2'b00;
      in_valid = 1'b1;
      for (int a = 0; a < 32; a++) begin
         in_addr = AW'(a);
         step();
         chk($sformatf("dir_out%0d", a), o32, 32'd1 << a);
         chk($sformatf("dir_ov%0d", a), {31'd0, v32}, 1);
         chk($sformatf("dir_err%0d", a), {31'd0, e32}, 0);
      end
      in_valid = 1'b0;
      step();
      chk("dir_idle_out", o32, 0);
      chk("dir_idle_ov", {31'd0, v32}, 0);

      // reserved mode behaves as direct
      mode = 2'b11; in_valid = 1'b1; in_addr = 5'd7;
      step();
      chk("rsvd_out", o32, 32'h80);
      chk("rsvd_busy", {31'd0, b32}, 0);
      in_valid = 1'b0;

      // range check on DEPTH=20
      do_reset();
      in_valid = 1'b1; in_addr = 5'd25;
      step();
      chk("rng_out", o20, 0);
      chk("rng_ov", {31'd0, v20}, 0);
      chk("rng_err", {31'd0, e20}, 1);
      in_addr = 5'd19;
      step();
      chk("rng_edge_out", o20, 32'h80000);
      chk("rng_edge_err", {31'd0, e20}, 0);
      in_valid = 1'b0;
      step();
      chk("rng_err_clr", {31'd0, e20}, 0);

      // single sweep on DEPTH=8
      do_reset();
      mode = 2'b01; start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         start = 1'b0;
         chk($sformatf("ss_out%0d", i), o8, 32'd1 << i);
         chk($sformatf("ss_ov%0d", i), {31'd0, v8}, 1);
         chk($sformatf("ss_done%0d", i), {31'd0, d8}, (i == 7) ? 1 : 0);
         chk($sformatf("ss_busy%0d", i), {31'd0, b8}, (i == 7) ? 0 : 1);
      end
      step();
      chk("ss_end_out", o8, 0);
      chk("ss_end_busy", {31'd0, b8}, 0);
      chk("ss_end_done", {31'd0, d8}, 0);

      // stall then stop on DEPTH=8
      do_reset();
      mode = 2'b01; start = 1'b1;
      step(); start = 1'b0;
      chk("st_out0", o8, 32'h01);
      step(); chk("st_out1", o8, 32'h02);
      step(); chk("st_out2", o8, 32'h04);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("st_hold%0d", i), o8, 0);
         chk($sformatf("st_hold_ov%0d", i), {31'd0, v8}, 0);
         chk($sformatf("st_hold_busy%0d", i), {31'd0, b8}, 1);
      end
      stall = 1'b0;
      step(); chk("st_out3", o8, 32'h08);
      step(); chk("st_out4", o8, 32'h10);
      stop = 1'b1;
      step();
      chk("stop_out", o8, 0);
      chk("stop_busy", {31'd0, b8}, 0);
      chk("stop_done", {31'd0, d8}, 0);
      stop = 1'b0;
      step();
      chk("stop_idle", o8, 0);

      // stop beats stall and the last-entry done on DEPTH=4
      do_reset();
      mode = 2'b01; start = 1'b1;
      step(); start = 1'b0;
      step();
      step(); chk("sp_pre", o4, 32'h4);
      stop = 1'b1; stall = 1'b1;
      step();
      chk("sp_out", o4, 0);
      chk("sp_done", {31'd0, d4}, 0);
      chk("sp_busy", {31'd0, b4}, 0);
      stop = 1'b0; stall = 1'b0;

      // continuous sweep on DEPTH=4, mode change ignored
      do_reset();
      mode = 2'b10; start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 0) begin
            start = 1'b0;
            mode = 2'b01;
         end
         chk($sformatf("cs_out%0d", k), o4, 32'd1 << (k % 4));
         chk($sformatf("cs_done%0d", k), {31'd0, d4},
             (k % 4 == 3) ? 1 : 0);
         chk($sformatf("cs_busy%0d", k), {31'd0, b4}, 1);
      end
      stop = 1'b1;
      step();
      chk("cs_stop_out", o4, 0);
      chk("cs_stop_busy", {31'd0, b4}, 0);
      stop = 1'b0;

      // single-entry sweep
      do_reset();
      mode = 2'b01; start = 1'b1;
      step(); start = 1'b0;
      chk("d1_out", o1, 32'h1);
      chk("d1_done", {31'd0, d1}, 1);
      chk("d1_busy", {31'd0, b1}, 0);
      step();
      chk("d1_after", o1, 0);
      chk("d1_after_done", {31'd0, d1}, 0);
      mode = 2'b10; start = 1'b1;
      step(); start = 1'b0;
      chk("d1c_out0", o1, 32'h1);
      chk("d1c_done0", {31'd0, d1}, 1);
      step();
      chk("d1c_out1", o1, 32'h1);
      chk("d1c_done1", {31'd0, d1}, 1);
      chk("d1c_busy", {31'd0, b1}, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("d1c_stop", o1, 0);

      // async reset mid-sweep, then relaunch
      do_reset();
      mode = 2'b01; start = 1'b1;
      step(); start = 1'b0;
      step();
      step();
      chk("mr_pre", o8, 32'h04);
      #3 rst = 1'b1;
      #1;
      chk("mr_out", o8, 0);
      chk("mr_busy", {31'd0, b8}, 0);
      chk("mr_ov", {31'd0, v8}, 0);
      chk("mr_done", {31'd0, d8}, 0);
      step();
      rst = 1'b0;
      step();
      chk("mr_idle_out", o8, 0);
      chk("mr_idle_busy", {31'd0, b8}, 0);
      start = 1'b1;
      step(); start = 1'b0;
      chk("mr_restart", o8, 32'h01);
      chk("mr_restart_busy", {31'd0, b8}, 1);
      step();
      chk("mr_restart2", o8, 32'h02);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/onehot_wsel.md
ONEHOT_WSEL -- requirements
Module: onehot_wsel

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the select address width.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the number of entries used, legal range 1..2**ADDR_W.
REQ-003 SHALL derive localparam OUT_W = 2**ADDR_W, meaning the one-hot output width.
REQ-004 SHALL have port clk  input  1  the single clock, with all state on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port mode  input  2  operating mode: 00 direct, 01 single sweep, 10 continuous sweep, 11 reserved (treated as 00).
REQ-007 SHALL have port in_valid  input  1  direct-mode request qualifier.
REQ-008 SHALL have port in_addr  input  ADDR_W  direct-mode select address.
REQ-009 SHALL have port start  input  1  sweep launch request.
REQ-010 SHALL have port stall  input  1  sweep hold.
REQ-011 SHALL have port stop  input  1  sweep abort.
REQ-012 SHALL have port out  output  OUT_W  registered one-hot select.
REQ-013 SHALL have port out_valid  output  1  out carries a select this cycle.
REQ-014 SHALL have port busy  output  1  FSM is in SWEEP.
REQ-015 SHALL have port done  output  1  one-cycle pulse on the last entry of a pass.
REQ-016 SHALL have port err  output  1  one-cycle pulse on an out-of-range direct address.

Function
REQ-017 SHALL implement FSM states IDLE and SWEEP; mode SHALL be latched at sweep launch, and changes while busy SHALL be ignored.
REQ-018 SHALL have every output registered, with latency exactly 1 cycle from sampled input to out.
REQ-019 In IDLE with mode 00/11 and in_valid=1 and in_addr<DEPTH, out SHALL become onehot(in_addr) and out_valid SHALL be 1 for one cycle.
REQ-020 In IDLE with mode 00/11 and in_valid=1 and in_addr>=DEPTH, out SHALL be 0, out_valid SHALL be 0, and err SHALL pulse 1 for one cycle.
REQ-021 In IDLE with mode 01/10 and start=1, the next cycle SHALL have out=onehot(0) and out_valid=1, the internal count SHALL become 1, and the FSM SHALL go to SWEEP; in_valid SHALL be ignored.
REQ-022 In SWEEP without stall or stop, each cycle SHALL emit onehot(count) with out_valid=1, then count SHALL increment.
REQ-023 The cycle that emits index DEPTH-1 SHALL assert done; in single mode the FSM SHALL then go to IDLE; in continuous mode count SHALL wrap to 0 and the FSM SHALL stay in SWEEP.
REQ-024 stall=1 in SWEEP SHALL hold count and set out=0 and out_valid=0 for the next cycle; a stalled cycle SHALL never assert done.
REQ-025 stop=1 in SWEEP SHALL, on the next cycle, set out=0 and out_valid=0, return the FSM to IDLE, and suppress done; stop SHALL take priority over stall and over the last-entry done.
REQ-026 start, in_valid, and stop SHALL be ignored in states where they are not listed.
REQ-027 With DEPTH=1, a sweep launch SHALL emit onehot(0) with done=1 in the same cycle; single mode SHALL return to IDLE.
REQ-028 out SHALL always be zero or exactly one-hot, never multi-hot.

Reset
REQ-029 While rst=1, out=0, out_valid=0, busy=0, done=0, err=0, count=0, and state=IDLE SHALL hold, asynchronously and regardless of clk.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first cycle after release SHALL be IDLE.

Structure
REQ-031 Mode encodings (MODE_DIRECT, MODE_SINGLE, MODE_CONT) and the FSM state encodings SHALL live in the shared package onehot_wsel_pkg.
REQ-032 The combinational binary-to-one-hot conversion SHALL be a parametrised sub-module onehot_dec (ADDR_W in, 2**ADDR_W out), instantiated once and fed by a mux of in_addr/count.

Verification
REQ-033 Direct mode: ADDR_W=5, DEPTH=32, in_valid=1, in_addr=0..31 -> out=1<<addr one cycle later, out_valid=1, err=0; in_valid=0 -> out=0.
REQ-034 Range check: DEPTH=20, in_addr=25 -> out=0, out_valid=0, err=1 for 1 cycle.
REQ-035 Single sweep: DEPTH=8, start pulse -> out=0x01,0x02,...,0x80 on 8 consecutive cycles, done=1 with 0x80, then busy=0.
REQ-036 Stall/stop: DEPTH=8, stall held 3 cycles after 0x04 -> 3 zero cycles then 0x08; stop after 0x10 -> out=0, busy=0, no done.
REQ-037 Continuous mode: DEPTH=4 -> 0x1,0x2,0x4,0x8(done),0x1,... for 3 passes, with mode changed mid-run ignored.
REQ-038 Reset: rst asserted mid-sweep between clock edges -> out=0 and busy=0 immediately; start after release -> sweep restarts at 0x01.
